axi4_frame_reader: RTL and testbench
====================================

AXI4_FRAME_READER -- requirements
Module: axi4_frame_reader

Interface
REQ-001 SHALL have parameters: AXI_ADDR_WIDTH, 32, address width; AXI_DATA_WIDTH, 64, data width; BURST_BEATS, 16, beats per burst; FRAME_BYTES, 153600, bytes per frame (1200 bursts of 128 B); FIFO_DEPTH, 64, internal buffer depth in beats.
REQ-002 SHALL have these ports:
- clk_100Mhz  in  1  sole clock; one clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- frame_start  in  1  one-cycle pulse from the display timing that starts a frame read.
- FRAME_BASE_ADDR  in  32  frame buffer base; sampled on accepted frame_start.
- ARADDR  out  32  burst address.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- ARLEN  out  8  constant 15.
- ARSIZE  out  3  constant 3'b011.
- ARBURST  out  2  constant 2'b01 (INCR).
- ARCACHE  out  4  constant 4'b0010.
- ARPROT  out  3  constant 3'b000.
- RDATA  in  64  read data.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- RLAST  in  1  last beat of burst.
- RRESP  in  2  read response.
- m_data  out  64  pixel stream data, 4 RGB565 pixels per beat.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the downstream HDMI path.
- m_last  out  1  high on the final beat of a frame.
- state  out  2  FSM state for debug.
- ADDR_OFFSET  out  32  byte offset of the current burst.
- fifo_level  out  7  beats held in the buffer, 0..64.
- rresp_err  out  1  sticky error flag.

Function
REQ-003 SHALL use FSM states IDLE=0, CHECK=1, ADDR_SEND=2 and DATA_RECV=3.
REQ-004 In IDLE, the block SHALL wait for frame_start, then latch the base address, clear ADDR_OFFSET to 0, flush the buffer and go to CHECK.
REQ-005 In CHECK, the block SHALL go to ADDR_SEND when fifo_level <= FIFO_DEPTH-BURST_BEATS (48); otherwise it SHALL stay in CHECK.
REQ-006 In ADDR_SEND, ARVALID SHALL be 1 and ARADDR SHALL equal base+ADDR_OFFSET, held stable until the ARVALID&ARREADY handshake; on that handshake ARVALID SHALL drop next cycle and the FSM SHALL go to DATA_RECV.
REQ-007 Only one burst SHALL be outstanding at any time.
REQ-008 In DATA_RECV, RREADY SHALL be 1; elsewhere RREADY SHALL be 0.
REQ-009 In DATA_RECV, each RVALID beat SHALL be written to the buffer in the same cycle, and a 4-bit beat counter SHALL increment.
REQ-010 The burst SHALL end on the handshake where beat count is 15.
REQ-011 If RLAST disagrees with beat count 15 on any beat, rresp_err SHALL be set.
REQ-012 Any beat with RRESP != 0 SHALL set rresp_err; the data SHALL still be stored.
REQ-013 At burst end, ADDR_OFFSET SHALL advance by 128.
REQ-014 At burst end, if the new ADDR_OFFSET equals FRAME_BYTES the FSM SHALL go to IDLE; otherwise it SHALL go to CHECK.
REQ-015 The buffer SHALL be a synchronous first-word-fall-through FIFO of 65-bit entries (data plus last flag).
REQ-016 The last flag SHALL be set only on beat 15 of burst 1199.
REQ-017 m_valid SHALL be 1 exactly when fifo_level != 0, and m_data/m_last SHALL show the head entry.
REQ-018 A word written to an empty buffer SHALL appear on m_valid the cycle after the write.
REQ-019 A pop SHALL occur when m_valid&m_ready.
REQ-020 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-021 The buffer SHALL never overflow, as guaranteed by REQ-005; a push when fifo_level=64 SHALL be dropped and SHALL set rresp_err.
REQ-022 frame_start in IDLE or CHECK SHALL take effect immediately per REQ-004.
REQ-023 frame_start in ADDR_SEND or DATA_RECV SHALL set a pending flag; the in-flight burst SHALL complete on AXI with RREADY=1, and its beats SHALL be discarded and not written.
REQ-024 After the burst in REQ-023 ends, the block SHALL restart per REQ-004; a second frame_start while pending SHALL be ignored.
REQ-025 A pop on the same cycle as a flush SHALL be ignored, and fifo_level SHALL become 0.
REQ-026 ADDR_OFFSET SHALL never exceed FRAME_BYTES-128 while a burst is issued.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL set: state=IDLE, ARVALID=0, RREADY=0, ARADDR=0, ADDR_OFFSET=0, beat counter=0, fifo_level=0, m_valid=0, m_last=0, rresp_err=0, pending flag=0.
REQ-028 Reset SHALL override frame_start and any in-flight burst.
REQ-029 rresp_err SHALL clear only on rst.

Verification
REQ-030 Base 0x0100_0000, one frame_start, m_ready=1, AXI slave with zero wait -> 1200 AR handshakes at 0x0100_0000 step 0x80; 19200 stream beats; m_last only on beat 19200; state returns to 0.
REQ-031 m_ready=0 for 2000 cycles -> fifo_level holds at 48 or 64, never above 64; FSM parks in CHECK; no AR while fifo_level>48.
REQ-032 ARREADY delayed 7 cycles -> ARADDR/ARVALID stay stable for all 7 cycles; exactly one handshake.
REQ-033 frame_start at beat 5 of burst 300 -> remaining 11 beats accepted and discarded; next AR at the base with offset 0; fifo_level=0 right after the flush.
REQ-034 RRESP=2'b10 on one beat, or RLAST on beat 7 -> rresp_err=1 and stays 1 until rst; data count is unchanged.
REQ-035 rst asserted in DATA_RECV -> all outputs at reset values the next cycle; no stream output until a new frame_start.

Source files
------------

// File: rtl/axi4_frame_reader.sv
// axi4_frame_reader: fetches a frame buffer over AXI4 in fixed bursts and streams it out of a FWFT buffer
module axi4_frame_reader #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int BURST_BEATS    = 16,
    parameter int FRAME_BYTES    = 153600,
    parameter int FIFO_DEPTH     = 64
) (
    input  logic                               clk_100Mhz,
    input  logic                               rst,
    input  logic                               frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0]          FRAME_BASE_ADDR,
    output logic [AXI_ADDR_WIDTH-1:0]          ARADDR,
    output logic                               ARVALID,
    input  logic                               ARREADY,
    output logic [7:0]                         ARLEN,
    output logic [2:0]                         ARSIZE,
    output logic [1:0]                         ARBURST,
    output logic [3:0]                         ARCACHE,
    output logic [2:0]                         ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0]          RDATA,
    input  logic                               RVALID,
    output logic                               RREADY,
    input  logic                               RLAST,
    input  logic [1:0]                         RRESP,
    output logic [AXI_DATA_WIDTH-1:0]          m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_last,
    output logic [1:0]                         state,
    output logic [AXI_ADDR_WIDTH-1:0]          ADDR_OFFSET,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               rresp_err
);
    localparam int BURST_BYTES = BURST_BEATS * AXI_DATA_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BURST_BEATS);

    typedef enum logic [1:0] {IDLE, CHECK, ADDR_SEND, DATA_RECV} state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d, off_q, off_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      pend_q, pend_d, err_q, err_d;
    logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]             cnt_q, cnt_d;
    logic [AXI_DATA_WIDTH:0]   mem [FIFO_DEPTH];

    logic beat_hs, last_beat, last_burst, drop, flush, full, fits, push, pop;

    assign ARADDR      = base_q + off_q;
    assign ARVALID     = state_q == ADDR_SEND;
    assign RREADY      = state_q == DATA_RECV;
    assign ARLEN       = 8'(BURST_BEATS - 1);
    assign ARSIZE      = 3'b011;
    assign ARBURST     = 2'b01;
    assign ARCACHE     = 4'b0010;
    assign ARPROT      = 3'b000;
    assign m_valid     = cnt_q != '0;
    assign m_data      = mem[rd_q][AXI_DATA_WIDTH-1:0];
    assign m_last      = m_valid && mem[rd_q][AXI_DATA_WIDTH];
    assign state       = state_q;
    assign ADDR_OFFSET = off_q;
    assign fifo_level  = cnt_q;
    assign rresp_err   = err_q;

    // Handshake strobes and buffer bookkeeping; beats of a burst overtaken by a new frame are dropped
    always_comb begin
        beat_hs    = state_q == DATA_RECV && RVALID;
        last_beat  = beat_q == BW'(BURST_BEATS - 1);
        last_burst = off_q == AXI_ADDR_WIDTH'(FRAME_BYTES - BURST_BYTES);
        drop       = pend_q || (frame_start && state_q == DATA_RECV);
        full       = cnt_q == LW'(FIFO_DEPTH);
        fits       = cnt_q <= LW'(FIFO_DEPTH - BURST_BEATS);
        flush      = (frame_start && (state_q == IDLE || state_q == CHECK)) || (beat_hs && last_beat && drop);
        push       = beat_hs && !drop && !full;
        pop        = m_valid && m_ready && !flush;
        cnt_d      = flush ? '0 : cnt_q + LW'(push) - LW'(pop);
        wr_d       = flush ? '0 : wr_q + PW'(push);
        rd_d       = flush ? '0 : rd_q + PW'(pop);
    end

    // Next-state logic: one burst at a time, throttled by buffer space
    always_comb begin
        state_d = state_q;
        base_d  = (frame_start && !pend_q) ? FRAME_BASE_ADDR : base_q;
        off_d   = off_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        err_d   = err_q || (beat_hs && !drop && full);
        case (state_q)
            IDLE, CHECK: begin
                if (frame_start) begin
                    off_d   = '0;
                    state_d = CHECK;
                end else if (state_q == CHECK && fits) begin
                    state_d = ADDR_SEND;
                end
            end
            ADDR_SEND: begin
                pend_d  = pend_q || frame_start;
                state_d = ARREADY ? DATA_RECV : ADDR_SEND;
            end
            DATA_RECV: begin
                pend_d = drop;
                if (RVALID) begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    err_d  = err_d || (RLAST != last_beat) || (RRESP != 2'b00);
                    if (last_beat) begin
                        pend_d  = 1'b0;
                        off_d   = drop ? '0 : off_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                        state_d = (drop || !last_burst) ? CHECK : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and buffer pointer registers
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            beat_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Buffer storage; the frame-end flag rides with the final beat of the final burst
    always_ff @(posedge clk_100Mhz) begin
        if (push) mem[wr_q] <= {last_beat && last_burst, RDATA};
    end
endmodule

// File: tb/tb_axi4_frame_reader.sv
// tb_axi4_frame_reader: AXI slave model plus scoreboard for the frame reader
module tb_axi4_frame_reader;
    logic        clk_100Mhz = 0, rst, frame_start, ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic        m_valid, m_ready, m_last, rresp_err;
    logic [31:0] FRAME_BASE_ADDR, ARADDR, ADDR_OFFSET;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE, ARPROT;
    logic [1:0]  ARBURST, RRESP, state;
    logic [3:0]  ARCACHE;
    logic [63:0] RDATA, m_data;
    logic [6:0]  fifo_level;

    axi4_frame_reader dut (
        .clk_100Mhz(clk_100Mhz), .rst(rst), .frame_start(frame_start), .FRAME_BASE_ADDR(FRAME_BASE_ADDR),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .RDATA(RDATA), .RVALID(RVALID),
        .RREADY(RREADY), .RLAST(RLAST), .RRESP(RRESP), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .state(state), .ADDR_OFFSET(ADDR_OFFSET),
        .fifo_level(fifo_level), .rresp_err(rresp_err)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int errors = 0, checks = 0;
    logic [64:0] q[$];
    logic        skip = 0, main_fs = 0;
    int ar_delay = 0, fs_burst = -1, fs_beat = 0, err_kind = 0, err_burst = 0, err_beat = 0;
    int ar_hs = 0, cur_burst = 0, nburst = 0, beats_left = 0, beat = 0, wait_cnt = 0;
    int disc_cnt = 0, restarts = 0, pops = 0, last_cnt = 0;
    logic [31:0] exp_addr = 0;
    logic        discard = 0, ar_just = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AXI slave: decides each cycle's inputs half a cycle before the edge and records expected stream beats
    initial begin
        logic hit;
        frame_start = 0; ARREADY = 0; RVALID = 0; RDATA = 0; RLAST = 0; RRESP = 0;
        forever begin
            @(negedge clk_100Mhz); #1;
            skip = 0;
            frame_start = 0;
            if (rst) begin
                q.delete(); skip = 1; beats_left = 0; beat = 0; wait_cnt = 0; ar_just = 0; discard = 0;
                ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0;
            end else begin
                if (ar_just) chk("arvalid_drop", 64'(ARVALID), 0);
                ar_just = 0;
                if (main_fs) begin
                    frame_start = 1; exp_addr = FRAME_BASE_ADDR; nburst = 0;
                    if (state < 2) begin q.delete(); skip = 1; end
                end
                hit    = cur_burst == err_burst && beat == err_beat;
                RVALID = beats_left > 0;
                RDATA  = {FRAME_BASE_ADDR, 16'(cur_burst), 16'(beat)};
                RLAST  = RVALID && (beat == 15 || (err_kind == 2 && hit));
                RRESP  = (RVALID && err_kind == 1 && hit) ? 2'b10 : 2'b00;
                if (RVALID && RREADY) begin
                    if (cur_burst == fs_burst && beat == fs_beat && !discard) begin
                        frame_start = 1; discard = 1;
                    end
                    if (discard) disc_cnt++;
                    else q.push_back({cur_burst == 1199 && beat == 15, RDATA});
                    beat++; beats_left--;
                    if (beats_left == 0 && discard) begin
                        q.delete(); skip = 1; exp_addr = FRAME_BASE_ADDR; nburst = 0; discard = 0; restarts++;
                    end
                end
                ARREADY = 0;
                if (ARVALID) begin
                    chk("araddr", 64'(ARADDR), 64'(exp_addr));
                    chk("one_outstanding", 64'(beats_left), 0);
                    if (wait_cnt >= ar_delay) begin
                        ARREADY = 1;
                        chk("ar_level", 64'(fifo_level <= 48), 1);
                        ar_hs++; cur_burst = nburst; nburst++; exp_addr += 128;
                        beats_left = 16; beat = 0; wait_cnt = 0; ar_just = 1;
                    end else wait_cnt++;
                end
            end
        end
    end

    // Stream monitor: pops the scoreboard on every accepted output beat
    initial forever begin
        logic [64:0] e;
        @(negedge clk_100Mhz); #2;
        if (!rst && !skip && m_valid && m_ready) begin
            if (q.size() == 0) chk("stream_unexpected", 1, 0);
            else begin
                e = q.pop_front();
                chk("m_data", m_data, e[63:0]);
                chk("m_last", 64'(m_last), 64'(e[64]));
                pops++;
                if (m_last) last_cnt++;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk_100Mhz); rst = 1;
        @(negedge clk_100Mhz);
        @(negedge clk_100Mhz); rst = 0;
    endtask

    task automatic start_frame(input logic [31:0] b);
        @(negedge clk_100Mhz); FRAME_BASE_ADDR = b; main_fs = 1;
        @(negedge clk_100Mhz); main_fs = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 64'(state), 0);
        chk({tag, "_arvalid"}, 64'(ARVALID), 0);
        chk({tag, "_rready"}, 64'(RREADY), 0);
        chk({tag, "_araddr"}, 64'(ARADDR), 0);
        chk({tag, "_offset"}, 64'(ADDR_OFFSET), 0);
        chk({tag, "_level"}, 64'(fifo_level), 0);
        chk({tag, "_mvalid"}, 64'(m_valid), 0);
        chk({tag, "_mlast"}, 64'(m_last), 0);
        chk({tag, "_err"}, 64'(rresp_err), 0);
    endtask

    initial begin
        int s, p, l, mx;
        rst = 1; m_ready = 1; FRAME_BASE_ADDR = 0;
        do_reset();
        chk_reset_vals("reset");
        chk("arlen", 64'(ARLEN), 15);
        chk("arsize", 64'(ARSIZE), 3);
        chk("arburst", 64'(ARBURST), 1);
        chk("arcache", 64'(ARCACHE), 2);
        chk("arprot", 64'(ARPROT), 0);

        // Full frame, zero-wait slave, always-ready sink
        s = ar_hs; p = pops; l = last_cnt;
        start_frame(32'h0100_0000);
        for (int i = 0; i < 30000 && !(ar_hs == s + 1200 && state == 0); i++) @(negedge clk_100Mhz);
        repeat (50) @(negedge clk_100Mhz);
        chk("frame_ar_count", 64'(ar_hs - s), 1200);
        chk("frame_beats", 64'(pops - p), 19200);
        chk("frame_last_count", 64'(last_cnt - l), 1);
        chk("frame_state", 64'(state), 0);
        chk("frame_drained", 64'(q.size()), 0);
        chk("frame_err", 64'(rresp_err), 0);

        // Delayed ARREADY, then reset mid-burst
        ar_delay = 7; s = ar_hs;
        start_frame(32'h0200_0000);
        for (int i = 0; i < 500 && !(ar_hs >= s + 3 && state == 3); i++) @(negedge clk_100Mhz);
        chk("delay_reached", 64'(ar_hs >= s + 3 && state == 3), 1);
        rst = 1;
        @(negedge clk_100Mhz); rst = 0;
        chk_reset_vals("midburst_rst");
        repeat (50) @(negedge clk_100Mhz);
        chk("post_rst_mvalid", 64'(m_valid), 0);
        chk("post_rst_state", 64'(state), 0);
        chk("post_rst_arvalid", 64'(ARVALID), 0);
        ar_delay = 0;

        // Stalled sink: buffer fills and the FSM parks in CHECK
        m_ready = 0; mx = 0;
        start_frame(32'h0300_0000);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_100Mhz);
            if (fifo_level > mx) mx = fifo_level;
        end
        chk("stall_max_level", 64'(mx), 64);
        chk("stall_level", 64'(fifo_level), 64);
        chk("stall_state", 64'(state), 1);
        chk("stall_sb_level", 64'(q.size()), 64'(fifo_level));
        m_ready = 1;
        repeat (300) @(negedge clk_100Mhz);
        do_reset();

        // frame_start at beat 5 of burst 300
        fs_burst = 300; fs_beat = 5; s = disc_cnt; p = restarts;
        start_frame(32'h0400_0000);
        for (int i = 0; i < 8000 && cur_burst != 300; i++) @(negedge clk_100Mhz);
        m_ready = 0;
        for (int i = 0; i < 100 && restarts == p; i++) @(negedge clk_100Mhz);
        @(negedge clk_100Mhz);
        chk("restart_seen", 64'(restarts - p), 1);
        chk("discarded_beats", 64'(disc_cnt - s), 11);
        chk("flush_level", 64'(fifo_level), 0);
        chk("flush_mvalid", 64'(m_valid), 0);
        chk("flush_offset", 64'(ADDR_OFFSET), 0);
        fs_burst = -1; m_ready = 1; s = ar_hs;
        for (int i = 0; i < 200 && ar_hs < s + 2; i++) @(negedge clk_100Mhz);
        chk("restart_ar", 64'(ar_hs >= s + 2), 1);
        do_reset();

        // RRESP error on one beat
        err_kind = 1; err_burst = 2; err_beat = 4; s = ar_hs;
        start_frame(32'h0500_0000);
        chk("err_clear_before", 64'(rresp_err), 0);
        for (int i = 0; i < 500 && ar_hs < s + 5; i++) @(negedge clk_100Mhz);
        chk("rresp_err_set", 64'(rresp_err), 1);
        chk("rresp_sb_level", 64'(q.size()), 64'(fifo_level));
        repeat (100) @(negedge clk_100Mhz);
        chk("rresp_err_sticky", 64'(rresp_err), 1);
        do_reset();
        chk("rresp_err_rst", 64'(rresp_err), 0);

        // Early RLAST on beat 7
        err_kind = 2; err_burst = 1; err_beat = 7; s = ar_hs;
        start_frame(32'h0600_0000);
        for (int i = 0; i < 500 && ar_hs < s + 4; i++) @(negedge clk_100Mhz);
        chk("rlast_err_set", 64'(rresp_err), 1);
        chk("rlast_sb_level", 64'(q.size()), 64'(fifo_level));
        do_reset();
        err_kind = 0;
        chk("final_err_clear", 64'(rresp_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
